// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing types, standard mode constants and sync-vector layout
package vga_pkg;

    typedef struct packed {
        int display;
        int front;
        int sync;
        int back;
    } vga_axis_t;

    typedef struct packed {
        vga_axis_t h;
        vga_axis_t v;
    } vga_timing_t;

    localparam vga_timing_t VGA_640x480_60 = '{h: '{640, 16, 96, 48}, v: '{480, 10, 2, 33}};
    localparam vga_timing_t VGA_800x600_60 = '{h: '{800, 40, 128, 88}, v: '{600, 1, 4, 23}};

    typedef enum logic {
        POL_LOW  = 1'b0,
        POL_HIGH = 1'b1
    } vga_pol_e;

    // Bit positions of the decoded timing vector carried through the delay line.
    localparam int SYNC_W = 5;
    localparam int SIG_HS = 0;
    localparam int SIG_VS = 1;
    localparam int SIG_VO = 2;
    localparam int SIG_LS = 3;
    localparam int SIG_FS = 4;

    function automatic int axis_total(input vga_axis_t a);
        return a.display + a.front + a.sync + a.back;
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// rtl/vga_sync_delay.sv - pixel-tick gated shift register aligning timing with the pixel pipeline
// Ports: clk_i clock, rst_ni async active-low clear, adv_i shift enable (pixel tick),
//        d_i W-bit input, q_o W-bit output delayed DEPTH ticks (DEPTH=0: passthrough).
module vga_sync_delay #(
    parameter int W     = 5,
    parameter int DEPTH = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         adv_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    if (DEPTH == 0) begin : g_pass
        logic unused_ctrl;
        assign unused_ctrl = ^{clk_i, rst_ni, adv_i};
        assign q_o = d_i;
    end else begin : g_pipe
        logic [W-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
            end else if (adv_i) begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing: prescaler, H/V counters, programmable sync, strobes
// Ports: clk, reset_n (async active-low), en (0 freezes everything); outputs p_tick pixel strobe,
//        x/y counters, hsync/vsync (polarity HS_POL/VS_POL), video_on, line_start, frame_start.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA_640x480_60.h.display,
    parameter int H_FRONT   = VGA_640x480_60.h.front,
    parameter int H_SYNC    = VGA_640x480_60.h.sync,
    parameter int H_BACK    = VGA_640x480_60.h.back,
    parameter int V_DISPLAY = VGA_640x480_60.v.display,
    parameter int V_FRONT   = VGA_640x480_60.v.front,
    parameter int V_SYNC    = VGA_640x480_60.v.sync,
    parameter int V_BACK    = VGA_640x480_60.v.back,
    parameter int CLK_DIV   = 4,
    parameter bit HS_POL    = POL_LOW,
    parameter bit VS_POL    = POL_LOW,
    parameter int PIPE_DLY  = 1,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int CW       = $clog2((H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          en,
    output logic          p_tick,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          hsync,
    output logic          vsync,
    output logic          video_on,
    output logic          line_start,
    output logic          frame_start
);

    if (CLK_DIV < 1) begin : g_bad_div
        $error("vga_timing_gen: CLK_DIV must be >= 1");
    end
    if (H_DISPLAY < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_DISPLAY < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_geom
        $error("vga_timing_gen: all H_/V_ timing parameters must be >= 1");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 4) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..4");
    end

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS    = CW'(H_DISPLAY);
    localparam logic [CW-1:0] V_VIS    = CW'(V_DISPLAY);
    localparam logic [CW-1:0] HS_START = CW'(H_DISPLAY + H_FRONT);
    localparam logic [CW-1:0] HS_STOP  = CW'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [CW-1:0] VS_START = CW'(V_DISPLAY + V_FRONT);
    localparam logic [CW-1:0] VS_STOP  = CW'(V_DISPLAY + V_FRONT + V_SYNC);

    logic [DW-1:0]     div_q, div_d;
    logic [CW-1:0]     x_q, x_d, y_q, y_d;
    logic              tick;
    logic [SYNC_W-1:0] raw, dly, lvl;

    // Gated by reset_n so the strobe is low for the whole time reset is held,
    // not just after the first clock edge.
    assign tick = en && reset_n && (div_q == '0);

    always_comb begin
        div_d = div_q;
        x_d   = x_q;
        y_d   = y_q;
        if (en) div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            div_q <= div_d;
            x_q   <= x_d;
            y_q   <= y_d;
        end
    end

    always_comb begin
        raw         = '0;
        raw[SIG_HS] = (x_q >= HS_START) && (x_q < HS_STOP);
        raw[SIG_VS] = (y_q >= VS_START) && (y_q < VS_STOP);
        raw[SIG_VO] = (x_q < H_VIS) && (y_q < V_VIS);
        raw[SIG_LS] = (x_q == '0);
        raw[SIG_FS] = (x_q == '0) && (y_q == '0);
    end

    vga_sync_delay #(
        .W     (SYNC_W),
        .DEPTH (PIPE_DLY)
    ) u_delay (
        .clk_i  (clk),
        .rst_ni (reset_n),
        .adv_i  (tick),
        .d_i    (raw),
        .q_o    (dly)
    );

    // With PIPE_DLY=0 the raw decode at (0,0) reads as visible; masking keeps
    // the levels at their idle values while reset is asserted.
    assign lvl = dly & {SYNC_W{reset_n}};

    assign p_tick      = tick;
    assign x           = x_q;
    assign y           = y_q;
    assign hsync       = lvl[SIG_HS] ? HS_POL : ~HS_POL;
    assign vsync       = lvl[SIG_VS] ? VS_POL : ~VS_POL;
    assign video_on    = lvl[SIG_VO];
    assign line_start  = lvl[SIG_LS] && tick;
    assign frame_start = lvl[SIG_FS] && tick;

endmodule
